// File: rtl/neighbor_table_writer.sv
// Inserts/updates a neighbor (ID, value, hop) entry in shared memory, then rescans for the best entry.
// Latency: new entry at count n takes 2 + 2n + 4 + 6(n+1) + 1 cycles from start; an update skips ID/count writes.
// Backpressure: none; start is accepted only in IDLE and ignored while busy.
module neighbor_table_writer #(
    parameter logic [10:0] TABLE_BASE    = 11'h000,
    parameter int          MAX_NEIGHBORS = 8,
    parameter int          ENTRY_STRIDE  = 6
) (
    input  logic        clock,
    input  logic        nrst,
    input  logic        start,
    input  logic [15:0] adv_id,
    input  logic [15:0] adv_value,
    input  logic [15:0] adv_hop,
    output logic [10:0] address,
    output logic        wr_en,
    output logic [15:0] mem_data_in,
    input  logic [15:0] mem_data_out,
    output logic        busy,
    output logic        done,
    output logic        dropped,
    output logic [15:0] neighbor_count,
    output logic [15:0] bestvalue,
    output logic [15:0] besthop,
    output logic [15:0] bestneighborID
);

    localparam int IW = $clog2(MAX_NEIGHBORS + 1);

    typedef struct packed {
        logic [15:0] id;
        logic [15:0] value;
        logic [15:0] hop;
    } entry_t;

    typedef enum logic [3:0] {
        S_INIT, S_IDLE, S_SCAN_START, S_SCAN_RD, S_WR_ID, S_WR_VAL,
        S_WR_HOP, S_WR_CNT, S_BEST_START, S_BEST_RD, S_DONE
    } state_t;

    state_t        state, n_state;
    logic          init_ph, n_init_ph;
    logic [10:0]   n_address;
    logic          n_wr_en, n_done, n_dropped;
    logic [15:0]   n_mem_data_in, n_count;
    logic [15:0]   n_bestvalue, n_besthop, n_bestneighborID;
    entry_t        adv, n_adv, run, n_run, cand, best_upd;
    logic [IW-1:0] idx, n_idx, slot, n_slot;
    logic [1:0]    fld, n_fld;
    logic          ph, n_ph, last;
    logic [15:0]   cur_val, n_cur_val, cur_hop, n_cur_hop;

    function automatic logic [10:0] ent(input logic [IW-1:0] i, input logic [10:0] off);
        return TABLE_BASE + 11'd2 + 11'(ENTRY_STRIDE) * 11'(i) + off;
    endfunction

    assign busy = (state != S_IDLE);

    always_ff @(posedge clock or negedge nrst) begin
        if (!nrst) begin
            state          <= S_INIT;
            init_ph        <= 1'b0;
            address        <= '0;
            wr_en          <= 1'b0;
            mem_data_in    <= '0;
            done           <= 1'b0;
            dropped        <= 1'b0;
            neighbor_count <= '0;
            bestvalue      <= 16'hFFFF;
            besthop        <= '0;
            bestneighborID <= 16'hFFFF;
            adv            <= '0;
            run            <= '0;
            idx            <= '0;
            slot           <= '0;
            fld            <= '0;
            ph             <= 1'b0;
            cur_val        <= '0;
            cur_hop        <= '0;
        end else begin
            state          <= n_state;
            init_ph        <= n_init_ph;
            address        <= n_address;
            wr_en          <= n_wr_en;
            mem_data_in    <= n_mem_data_in;
            done           <= n_done;
            dropped        <= n_dropped;
            neighbor_count <= n_count;
            bestvalue      <= n_bestvalue;
            besthop        <= n_besthop;
            bestneighborID <= n_bestneighborID;
            adv            <= n_adv;
            run            <= n_run;
            idx            <= n_idx;
            slot           <= n_slot;
            fld            <= n_fld;
            ph             <= n_ph;
            cur_val        <= n_cur_val;
            cur_hop        <= n_cur_hop;
        end
    end

    // Memory port outputs are registered: each state loads the address/data the next state presents.
    always_comb begin
        n_state          = state;
        n_init_ph        = init_ph;
        n_address        = address;
        n_wr_en          = 1'b0;
        n_mem_data_in    = mem_data_in;
        n_done           = 1'b0;
        n_dropped        = dropped;
        n_count          = neighbor_count;
        n_bestvalue      = bestvalue;
        n_besthop        = besthop;
        n_bestneighborID = bestneighborID;
        n_adv            = adv;
        n_run            = run;
        n_idx            = idx;
        n_slot           = slot;
        n_fld            = fld;
        n_ph             = ph;
        n_cur_val        = cur_val;
        n_cur_hop        = cur_hop;
        last             = (16'(idx) == neighbor_count - 16'd1);
        cand             = '{id: mem_data_out, value: cur_val, hop: cur_hop};
        best_upd         = (cur_val < run.value) ? cand : run;

        case (state)
            S_INIT: begin
                // First cycle arms the count-clear write, second cycle presents it.
                if (!init_ph) begin
                    n_init_ph     = 1'b1;
                    n_address     = TABLE_BASE;
                    n_mem_data_in = '0;
                    n_wr_en       = 1'b1;
                end else begin
                    n_state = S_IDLE;
                end
            end
            S_IDLE: begin
                if (start) begin
                    n_adv     = '{id: adv_id, value: adv_value, hop: adv_hop};
                    n_dropped = 1'b0;
                    n_state   = S_SCAN_START;
                end
            end
            S_SCAN_START: begin
                if (neighbor_count == 16'd0) begin
                    n_slot        = '0;
                    n_address     = ent('0, 11'd0);
                    n_mem_data_in = adv.id;
                    n_wr_en       = 1'b1;
                    n_state       = S_WR_ID;
                end else begin
                    n_idx     = '0;
                    n_ph      = 1'b0;
                    n_address = ent('0, 11'd0);
                    n_state   = S_SCAN_RD;
                end
            end
            S_SCAN_RD: begin
                if (!ph) begin
                    n_ph = 1'b1;
                end else if (mem_data_out == adv.id) begin
                    n_slot        = idx;
                    n_address     = ent(idx, 11'd2);
                    n_mem_data_in = adv.value;
                    n_wr_en       = 1'b1;
                    n_state       = S_WR_VAL;
                end else if (last) begin
                    if (neighbor_count < 16'(MAX_NEIGHBORS)) begin
                        n_slot        = neighbor_count[IW-1:0];
                        n_address     = ent(neighbor_count[IW-1:0], 11'd0);
                        n_mem_data_in = adv.id;
                        n_wr_en       = 1'b1;
                        n_state       = S_WR_ID;
                    end else begin
                        n_dropped = 1'b1;
                        n_state   = S_BEST_START;
                    end
                end else begin
                    n_idx     = idx + IW'(1);
                    n_ph      = 1'b0;
                    n_address = ent(idx + IW'(1), 11'd0);
                end
            end
            S_WR_ID: begin
                n_address     = ent(slot, 11'd2);
                n_mem_data_in = adv.value;
                n_wr_en       = 1'b1;
                n_state       = S_WR_VAL;
            end
            S_WR_VAL: begin
                n_address     = ent(slot, 11'd4);
                n_mem_data_in = adv.hop;
                n_wr_en       = 1'b1;
                n_state       = S_WR_HOP;
            end
            S_WR_HOP: begin
                // Slot equal to count means this was an append, so the count word must follow.
                if (16'(slot) == neighbor_count) begin
                    n_address     = TABLE_BASE;
                    n_mem_data_in = neighbor_count + 16'd1;
                    n_wr_en       = 1'b1;
                    n_state       = S_WR_CNT;
                end else begin
                    n_state = S_BEST_START;
                end
            end
            S_WR_CNT: begin
                n_count = neighbor_count + 16'd1;
                n_state = S_BEST_START;
            end
            S_BEST_START: begin
                n_run = '{id: 16'hFFFF, value: 16'hFFFF, hop: 16'h0000};
                if (neighbor_count == 16'd0) begin
                    n_bestvalue      = 16'hFFFF;
                    n_besthop        = 16'h0000;
                    n_bestneighborID = 16'hFFFF;
                    n_done           = 1'b1;
                    n_state          = S_DONE;
                end else begin
                    n_idx     = '0;
                    n_fld     = 2'd0;
                    n_ph      = 1'b0;
                    n_address = ent('0, 11'd2);
                    n_state   = S_BEST_RD;
                end
            end
            S_BEST_RD: begin
                if (!ph) begin
                    n_ph = 1'b1;
                end else begin
                    n_ph = 1'b0;
                    case (fld)
                        2'd0: begin
                            n_cur_val = mem_data_out;
                            n_fld     = 2'd1;
                            n_address = ent(idx, 11'd4);
                        end
                        2'd1: begin
                            n_cur_hop = mem_data_out;
                            n_fld     = 2'd2;
                            n_address = ent(idx, 11'd0);
                        end
                        default: begin
                            n_run = best_upd;
                            if (last) begin
                                n_bestvalue      = best_upd.value;
                                n_besthop        = best_upd.hop;
                                n_bestneighborID = best_upd.id;
                                n_done           = 1'b1;
                                n_state          = S_DONE;
                            end else begin
                                n_idx     = idx + IW'(1);
                                n_fld     = 2'd0;
                                n_address = ent(idx + IW'(1), 11'd2);
                            end
                        end
                    endcase
                end
            end
            S_DONE: begin
                n_state = S_IDLE;
            end
            default: begin
                n_state = S_INIT;
            end
        endcase
    end

endmodule

// File: tb/tb_neighbor_table_writer.sv
// Directed bench for neighbor_table_writer with a word-per-byte-address memory model.
module tb_neighbor_table_writer;

    logic        clock = 1'b0;
    logic        nrst;
    logic        start;
    logic [15:0] adv_id, adv_value, adv_hop;
    logic [10:0] address;
    logic        wr_en;
    logic [15:0] mem_data_in;
    logic [15:0] mem_data_out;
    logic        busy, done, dropped;
    logic [15:0] neighbor_count, bestvalue, besthop, bestneighborID;

    logic [15:0] mem [0:2047] = '{default: 16'hDEAD};
    int          wr_total = 0;
    int          checks = 0;
    int          errors = 0;

    always #5 clock = ~clock;

    // Synchronous memory: read data appears the cycle after the address.
    always @(posedge clock) begin
        if (wr_en) begin
            mem[address] <= mem_data_in;
            wr_total     <= wr_total + 1;
        end
        mem_data_out <= mem[address];
    end

    neighbor_table_writer dut (
        .clock(clock), .nrst(nrst), .start(start),
        .adv_id(adv_id), .adv_value(adv_value), .adv_hop(adv_hop),
        .address(address), .wr_en(wr_en), .mem_data_in(mem_data_in),
        .mem_data_out(mem_data_out), .busy(busy), .done(done), .dropped(dropped),
        .neighbor_count(neighbor_count), .bestvalue(bestvalue), .besthop(besthop),
        .bestneighborID(bestneighborID)
    );

    task automatic do_adv(input logic [15:0] id, input logic [15:0] val, input logic [15:0] hop,
                          input int extra_at, output int cyc, output int writes,
                          output logic [15:0] mid_val, output logic done_after);
        int w0;
        @(negedge clock);
        adv_id = id; adv_value = val; adv_hop = hop; start = 1'b1;
        @(posedge clock);
        w0 = wr_total;
        #1 start = 1'b0;
        cyc = 0;
        mid_val = bestvalue;
        while (cyc < 500) begin
            @(negedge clock);
            cyc++;
            if (cyc == 2) mid_val = bestvalue;
            start = (extra_at != 0 && cyc == extra_at);
            if (done) break;
        end
        writes = wr_total - w0;
        @(negedge clock);
        done_after = done;
        start = 1'b0;
    endtask

    task automatic wait_init();
        int n = 0;
        while (busy && n < 20) begin
            @(negedge clock);
            n++;
        end
    endtask

    task automatic test_reset();
        nrst = 1'b0; start = 1'b0; adv_id = '0; adv_value = '0; adv_hop = '0;
        repeat (2) @(negedge clock);
        checks++; if ({address, wr_en, mem_data_in, done, dropped} !== '0) begin errors++;
            $display("FAIL reset_port: addr=%0h wr_en=%0b data=%0h done=%0b dropped=%0b want all 0", address, wr_en, mem_data_in, done, dropped); end
        checks++; if (neighbor_count !== 16'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", neighbor_count); end
        checks++; if ({bestvalue, besthop, bestneighborID} !== {16'hFFFF, 16'h0, 16'hFFFF}) begin errors++;
            $display("FAIL reset_best: got %h/%h/%h want ffff/0000/ffff", bestvalue, besthop, bestneighborID); end
        nrst = 1'b1;
        wait_init();
        checks++; if (busy !== 1'b0 || mem[0] !== 16'd0) begin errors++;
            $display("FAIL init_clear: busy=%0b mem0=%h want busy=0 mem0=0000", busy, mem[0]); end
    endtask

    task automatic test_first_insert();
        int cyc, wr; logic [15:0] mid; logic da;
        do_adv(16'd4, 16'd8, 16'd50, 0, cyc, wr, mid, da);
        checks++; if (cyc !== 13) begin errors++; $display("FAIL first_latency: got %0d want 13", cyc); end
        checks++; if (da !== 1'b0) begin errors++; $display("FAIL done_pulse: done still %0b one cycle later, want 0", da); end
        checks++; if (mid !== 16'hFFFF) begin errors++; $display("FAIL first_hold: bestvalue mid-op %h want ffff", mid); end
        checks++; if ({mem[0], mem[2], mem[4], mem[6]} !== {16'd1, 16'd4, 16'd8, 16'd50}) begin errors++;
            $display("FAIL first_mem: got %0d,%0d,%0d,%0d want 1,4,8,50", mem[0], mem[2], mem[4], mem[6]); end
        checks++; if ({neighbor_count, bestvalue, besthop, bestneighborID, 15'd0, dropped} !== {16'd1, 16'd8, 16'd50, 16'd4, 16'd0}) begin errors++;
            $display("FAIL first_best: cnt=%0d best=%0d/%0d/%0d dropped=%0b want 1 8/50/4 0", neighbor_count, bestvalue, besthop, bestneighborID, dropped); end
        checks++; if (wr !== 4) begin errors++; $display("FAIL first_writes: got %0d want 4", wr); end
    endtask

    task automatic test_better_insert();
        int cyc, wr; logic [15:0] mid; logic da;
        do_adv(16'd7, 16'd3, 16'd20, 0, cyc, wr, mid, da);
        checks++; if (cyc !== 21) begin errors++; $display("FAIL better_latency: got %0d want 21", cyc); end
        checks++; if ({mem[0], mem[8], mem[10], mem[12]} !== {16'd2, 16'd7, 16'd3, 16'd20}) begin errors++;
            $display("FAIL better_mem: got %0d,%0d,%0d,%0d want 2,7,3,20", mem[0], mem[8], mem[10], mem[12]); end
        checks++; if ({neighbor_count, bestvalue, besthop, bestneighborID} !== {16'd2, 16'd3, 16'd20, 16'd7}) begin errors++;
            $display("FAIL better_best: cnt=%0d best=%0d/%0d/%0d want 2 3/20/7", neighbor_count, bestvalue, besthop, bestneighborID); end
    endtask

    task automatic test_update_worsen();
        int cyc, wr; logic [15:0] mid; logic da;
        do_adv(16'd7, 16'd9, 16'd20, 0, cyc, wr, mid, da);
        checks++; if (cyc !== 21) begin errors++; $display("FAIL update_latency: got %0d want 21", cyc); end
        checks++; if (mid !== 16'd3) begin errors++; $display("FAIL update_hold: bestvalue mid-op %0d want 3", mid); end
        checks++; if (wr !== 2 || mem[0] !== 16'd2 || mem[10] !== 16'd9) begin errors++;
            $display("FAIL update_mem: writes=%0d mem0=%0d val1=%0d want 2,2,9", wr, mem[0], mem[10]); end
        checks++; if ({neighbor_count, bestvalue, besthop, bestneighborID} !== {16'd2, 16'd8, 16'd50, 16'd4}) begin errors++;
            $display("FAIL update_best: cnt=%0d best=%0d/%0d/%0d want 2 8/50/4", neighbor_count, bestvalue, besthop, bestneighborID); end
    endtask

    task automatic test_tie();
        int cyc, wr; logic [15:0] mid; logic da;
        do_adv(16'd9, 16'd8, 16'd77, 0, cyc, wr, mid, da);
        checks++; if (cyc !== 29) begin errors++; $display("FAIL tie_latency: got %0d want 29", cyc); end
        checks++; if ({neighbor_count, bestvalue, besthop, bestneighborID} !== {16'd3, 16'd8, 16'd50, 16'd4}) begin errors++;
            $display("FAIL tie_best: cnt=%0d best=%0d/%0d/%0d want 3 8/50/4", neighbor_count, bestvalue, besthop, bestneighborID); end
    endtask

    task automatic test_fill_drop();
        int cyc, wr; logic [15:0] mid; logic da;
        for (int k = 0; k < 5; k++) begin
            do_adv(16'(10 + k), 16'(100 + k), 16'(1 + k), 0, cyc, wr, mid, da);
            checks++; if (neighbor_count !== 16'(4 + k)) begin errors++;
                $display("FAIL fill_count_%0d: got %0d want %0d", k, neighbor_count, 4 + k); end
        end
        checks++; if (mem[44] !== 16'd14 || mem[48] !== 16'd5) begin errors++;
            $display("FAIL fill_last: id=%0d hop=%0d want 14,5", mem[44], mem[48]); end
        do_adv(16'd99, 16'd1, 16'd1, 0, cyc, wr, mid, da);
        checks++; if (cyc !== 67) begin errors++; $display("FAIL drop_latency: got %0d want 67", cyc); end
        checks++; if (dropped !== 1'b1 || neighbor_count !== 16'd8 || mem[0] !== 16'd8) begin errors++;
            $display("FAIL drop_flag: dropped=%0b cnt=%0d mem0=%0d want 1,8,8", dropped, neighbor_count, mem[0]); end
        checks++; if (wr !== 0 || mem[50] !== 16'hDEAD) begin errors++; $display("FAIL drop_writes: got %0d writes mem50=%h want 0 dead", wr, mem[50]); end
        checks++; if ({bestvalue, besthop, bestneighborID} !== {16'd8, 16'd50, 16'd4}) begin errors++;
            $display("FAIL drop_best: got %0d/%0d/%0d want 8/50/4", bestvalue, besthop, bestneighborID); end
    endtask

    task automatic test_full_update();
        int cyc, wr; logic [15:0] mid; logic da;
        do_adv(16'd4, 16'd2, 16'd60, 0, cyc, wr, mid, da);
        checks++; if (cyc !== 55) begin errors++; $display("FAIL full_upd_latency: got %0d want 55", cyc); end
        checks++; if (dropped !== 1'b0 || wr !== 2 || mem[4] !== 16'd2 || mem[6] !== 16'd60) begin errors++;
            $display("FAIL full_upd_mem: dropped=%0b writes=%0d val=%0d hop=%0d want 0,2,2,60", dropped, wr, mem[4], mem[6]); end
        checks++; if ({neighbor_count, bestvalue, besthop, bestneighborID} !== {16'd8, 16'd2, 16'd60, 16'd4}) begin errors++;
            $display("FAIL full_upd_best: cnt=%0d best=%0d/%0d/%0d want 8 2/60/4", neighbor_count, bestvalue, besthop, bestneighborID); end
    endtask

    task automatic test_reset_mid();
        int cyc, wr; logic [15:0] mid; logic da;
        @(negedge clock);
        adv_id = 16'd5; adv_value = 16'd40; adv_hop = 16'd3; start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        repeat (3) @(negedge clock);
        nrst = 1'b0;
        #1;
        checks++; if ({address, wr_en, mem_data_in, done, dropped, neighbor_count} !== '0) begin errors++;
            $display("FAIL midrst_port: addr=%0h wr_en=%0b cnt=%0d done=%0b dropped=%0b want all 0", address, wr_en, neighbor_count, done, dropped); end
        checks++; if ({bestvalue, besthop, bestneighborID} !== {16'hFFFF, 16'h0, 16'hFFFF}) begin errors++;
            $display("FAIL midrst_best: got %h/%h/%h want ffff/0000/ffff", bestvalue, besthop, bestneighborID); end
        repeat (2) @(negedge clock);
        nrst = 1'b1;
        wait_init();
        checks++; if (busy !== 1'b0 || mem[0] !== 16'd0) begin errors++;
            $display("FAIL midrst_init: busy=%0b mem0=%0d want 0,0", busy, mem[0]); end
        do_adv(16'd5, 16'd40, 16'd3, 0, cyc, wr, mid, da);
        checks++; if (cyc !== 13 || neighbor_count !== 16'd1) begin errors++;
            $display("FAIL midrst_insert: latency=%0d cnt=%0d want 13,1", cyc, neighbor_count); end
        checks++; if ({bestvalue, besthop, bestneighborID} !== {16'd40, 16'd3, 16'd5}) begin errors++;
            $display("FAIL midrst_best2: got %0d/%0d/%0d want 40/3/5", bestvalue, besthop, bestneighborID); end
    endtask

    task automatic test_start_while_busy();
        int cyc, wr, extra; logic [15:0] mid; logic da;
        do_adv(16'd6, 16'd50, 16'd6, 4, cyc, wr, mid, da);
        checks++; if (cyc !== 21 || neighbor_count !== 16'd2) begin errors++;
            $display("FAIL busy_start_op: latency=%0d cnt=%0d want 21,2", cyc, neighbor_count); end
        extra = 0;
        repeat (60) begin
            @(negedge clock);
            if (done) extra++;
        end
        checks++; if (extra !== 0 || neighbor_count !== 16'd2) begin errors++;
            $display("FAIL busy_start_ignored: extra_done=%0d cnt=%0d want 0,2", extra, neighbor_count); end
        checks++; if ({bestvalue, besthop, bestneighborID} !== {16'd40, 16'd3, 16'd5}) begin errors++;
            $display("FAIL busy_start_best: got %0d/%0d/%0d want 40/3/5", bestvalue, besthop, bestneighborID); end
    endtask

    initial begin
        test_reset();
        test_first_insert();
        test_better_insert();
        test_update_worsen();
        test_tie();
        test_fill_drop();
        test_full_update();
        test_reset_mid();
        test_start_while_busy();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
